// File: rtl/memory_access_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
//   mem_req   : request, held until mem_ack, timeout or reset
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_rdata : read data, valid while mem_ack = 1
//   mem_ack   : one-cycle completion pulse
// The master modport is used by the pipeline stage and the slave modport by the memory.
interface memory_access_stage_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM pipeline stage of the 16-bit CPU.
// Sits between the EX/MEM and MEM/WB registers. Non-memory instructions pass
// straight through with no added cycles; loads and stores run a req/ack
// access on the data-memory bus while the front of the pipeline is stalled.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   ex_valid            : EX/MEM holds a real instruction
//   ex_memRead/Write    : load / store (both set => store)
//   ex_wbs, ex_ni       : forwarded unchanged to MEM/WB
//   ex_ALUresult        : ALU result, also the memory address
//   ex_storeData        : store data
//   stall               : freeze PC, IF/ID, ID/EX and EX/MEM
//   mem                 : data-memory bus (master side)
//   wb_valid            : MEM/WB inputs carry a real instruction this cycle
//   wbs_out, ni_out     : to MEM/WB
//   memData_out         : load data to MEM/WB (0 for non-loads and timeouts)
//   ALUresult_out       : to MEM/WB
//   mem_error           : sticky access-timeout flag, cleared only by reset
module memory_access_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   ex_memRead,
  input  logic                   ex_memWrite,
  input  logic                   ex_wbs,
  input  logic                   ex_ni,
  input  logic [DATA_W-1:0]      ex_ALUresult,
  input  logic [DATA_W-1:0]      ex_storeData,
  output logic                   stall,
  memory_access_stage_if.master  mem,
  output logic                   wb_valid,
  output logic                   wbs_out,
  output logic [DATA_W-1:0]      memData_out,
  output logic [DATA_W-1:0]      ALUresult_out,
  output logic                   ni_out,
  output logic                   mem_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Last counter value of an access: with the counter starting at 0 this
  // allows exactly TIMEOUT ACCESS cycles before the abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_wdata_q;
  logic              hold_we_q;
  logic              hold_wbs_q;
  logic              hold_ni_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;

  logic mem_op;
  logic timeout_hit;

  assign mem_op      = ex_valid & (ex_memRead | ex_memWrite);
  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_op) state_d = ACCESS;
      ACCESS:  if (mem.mem_ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hold registers, access counter, latched read data and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_we_q    <= 1'b0;
      hold_wbs_q   <= 1'b0;
      hold_ni_q    <= 1'b0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            hold_addr_q  <= ex_ALUresult;
            hold_wdata_q <= ex_storeData;
            // A store wins when both memRead and memWrite are set.
            hold_we_q    <= ex_memWrite;
            hold_wbs_q   <= ex_wbs;
            hold_ni_q    <= ex_ni;
            cnt_q        <= '0;
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem.mem_ack) begin
            rdata_q <= hold_we_q ? '0 : mem.mem_rdata;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic; everything is forced low while reset is asserted so that
  // the IDLE pass-through cannot leak the EX/MEM contents during reset.
  always_comb begin
    stall         = 1'b0;
    wb_valid      = 1'b0;
    wbs_out       = 1'b0;
    ni_out        = 1'b0;
    memData_out   = '0;
    ALUresult_out = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem_error     = 1'b0;
    if (rst_n) begin
      mem_error = error_q;
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            // Bubble towards MEM/WB while the access is set up.
            stall = 1'b1;
          end else begin
            wb_valid      = ex_valid;
            wbs_out       = ex_wbs & ex_valid;
            ni_out        = ex_ni & ex_valid;
            ALUresult_out = ex_valid ? ex_ALUresult : '0;
          end
        end
        ACCESS: begin
          stall         = 1'b1;
          mem.mem_req   = 1'b1;
          mem.mem_we    = hold_we_q;
          mem.mem_addr  = hold_addr_q;
          mem.mem_wdata = hold_wdata_q;
        end
        RESP: begin
          // EX/MEM still shows this instruction; the hold copy is used so the
          // result is independent of what the front of the pipeline does.
          wb_valid      = 1'b1;
          wbs_out       = hold_wbs_q;
          ni_out        = hold_ni_q;
          ALUresult_out = hold_addr_q;
          memData_out   = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios followed by random
// instruction streams. Expected MEM/WB results are queued at issue time from a
// reference memory; a monitor compares them whenever wb_valid is seen.
module tb_memory_access_stage;

  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_memRead, ex_memWrite, ex_wbs, ex_ni;
  logic [DW-1:0] ex_ALUresult, ex_storeData;
  logic          stall, wb_valid, wbs_out, ni_out, mem_error;
  logic [DW-1:0] memData_out, ALUresult_out;

  memory_access_stage_if #(.DATA_W(DW)) mif ();

  memory_access_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_memRead    (ex_memRead),
    .ex_memWrite   (ex_memWrite),
    .ex_wbs        (ex_wbs),
    .ex_ni         (ex_ni),
    .ex_ALUresult  (ex_ALUresult),
    .ex_storeData  (ex_storeData),
    .stall         (stall),
    .mem           (mif),
    .wb_valid      (wb_valid),
    .wbs_out       (wbs_out),
    .memData_out   (memData_out),
    .ALUresult_out (ALUresult_out),
    .ni_out        (ni_out),
    .mem_error     (mem_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic          wbs;
    logic          ni;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] phys    [256];
  int            cur_delay = 0;
  logic [DW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_we = 1'b0;
  logic          err_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: reset values and MEM/WB results against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      check("reset_outputs",
            {stall, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, wb_valid,
             wbs_out, ni_out, mem_error},
            64'd0);
      check("reset_data", {memData_out, ALUresult_out}, 64'd0);
    end else if (wb_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("wb_fields",
              {ALUresult_out, wbs_out, ni_out, memData_out, mem_error, mif.mem_req},
              {e.alu, e.wbs, e.ni, e.data, e.err, 1'b0});
      end
    end
  end

  // Memory responder: acks after cur_delay request cycles, plus spurious
  // acks while no request is pending.
  int req_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && mif.mem_req) begin
      check("mem_bus", {mif.mem_we, mif.mem_addr, mif.mem_wdata},
            {exp_we, exp_addr, exp_wdata});
      if (req_cnt == cur_delay) begin
        mif.mem_ack = 1'b1;
        if (mif.mem_we) begin
          phys[mif.mem_addr[7:0]] = mif.mem_wdata;
          mif.mem_rdata = DW'($urandom);
        end else begin
          mif.mem_rdata = phys[mif.mem_addr[7:0]];
        end
      end else begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = DW'($urandom);
      end
      req_cnt++;
    end else begin
      req_cnt       = 0;
      mif.mem_ack   = ($urandom_range(0, 3) == 0);
      mif.mem_rdata = DW'($urandom);
    end
  end

  // Presents one instruction at posedge+1 and holds it until the stage
  // releases the stall; returns at posedge+1 of the following cycle.
  task automatic issue(input logic v, input logic rd, input logic wr, input logic wb,
                       input logic n, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input int d);
    int   n_acc;
    int   cnt;
    logic mop;
    logic to;
    exp_t e;
    ex_valid     = v;
    ex_memRead   = rd;
    ex_memWrite  = wr;
    ex_wbs       = wb;
    ex_ni        = n;
    ex_ALUresult = alu;
    ex_storeData = sd;
    cur_delay    = d;
    exp_we       = wr;
    exp_addr     = alu;
    exp_wdata    = sd;
    mop   = v & (rd | wr);
    to    = mop && (d >= TO);
    n_acc = !mop ? 0 : (to ? TO : d + 1);
    if (to) err_exp = 1'b1;
    if (v) begin
      e.alu = alu;
      e.wbs = wb;
      e.ni  = n;
      e.err = err_exp;
      if (!mop || to) begin
        e.data = '0;
      end else if (wr) begin
        e.data = '0;
        ref_mem[alu[7:0]] = sd;
      end else begin
        e.data = ref_mem[alu[7:0]];
      end
      sb.push_back(e);
    end
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      check("bubble", {wb_valid, ALUresult_out, memData_out, wbs_out, ni_out}, 64'd0);
    end
    check("stall_cycles", 64'(cnt), mop ? 64'(1 + n_acc) : 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'($urandom);
      phys[i]    = ref_mem[i];
    end
    ref_mem[8'h40] = 16'hBEEF;
    phys[8'h40]    = 16'hBEEF;

    // Reset with a live instruction in EX/MEM.
    rst_n        = 1'b0;
    ex_valid     = 1'b1;
    ex_memRead   = 1'b0;
    ex_memWrite  = 1'b0;
    ex_wbs       = 1'b1;
    ex_ni        = 1'b1;
    ex_ALUresult = 16'h1234;
    ex_storeData = 16'h0000;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pass-through of the same instruction after release.
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 0);
    // ALU op, same-cycle result.
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA, 16'h0000, 0);
    // Load, ack in the third request cycle.
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2);
    // Store with immediate ack.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h5A5A, 0);
    // Read back the stored value.
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 1);
    // Load that times out; mem_error then stays set.
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000, 100);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0000, 0);
    // Ack in the last allowed cycle, and memRead+memWrite treated as a store.
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, TO - 1);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0041, 16'hC3C3, 0);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0041, 16'h0000, 0);
    // Invalid instruction carrying memRead: no access, no writeback.
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0050, 16'h0000, 0);

    // Reset in the second ACCESS cycle of a load.
    ex_valid     = 1'b1;
    ex_memRead   = 1'b1;
    ex_memWrite  = 1'b0;
    ex_ALUresult = 16'h0020;
    exp_we       = 1'b0;
    exp_addr     = 16'h0020;
    exp_wdata    = ex_storeData;
    cur_delay    = 100;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("req_before_reset", {63'd0, mif.mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_access", {mif.mem_req, stall, wb_valid, mem_error}, 64'd0);
    err_exp  = 1'b0;
    ex_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal operation after the reset.
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 0);

    // Random instruction stream.
    for (int k = 0; k < 150; k++) begin
      logic          v, rd, wr;
      logic [DW-1:0] a;
      int            kind;
      v    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 3);
      rd   = (kind == 1) || (kind == 3);
      wr   = (kind == 2) || (kind == 3);
      a    = {DW'($urandom_range(0, 255)) << 8} | DW'($urandom_range(0, 15));
      issue(v, rd, wr, 1'($urandom), 1'($urandom), a, DW'($urandom),
            $urandom_range(0, TO + 1));
    end

    ex_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
